// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one combinational signed array divider between
// two requesters (A, B) with round-robin arbitration.
//
// The operands of the granted request are registered onto Div_Dividend /
// Div_Divisor and held for SETTLE cycles, which makes the divider a
// multicycle path. The quotient is then sampled into a registered response
// on a valid/ready port. A zero divisor skips the divider and answers at once.
//
// Parameters
//   N       operand / quotient width
//   SETTLE  cycles the operands are held before the quotient is sampled (>=1)
//
// Ports
//   Clk, Reset_n          clock (rising edge), asynchronous active-low reset
//   ReqA_* / ReqB_*       Valid/Ready request ports, two's complement operands
//   Div_Dividend/Divisor  registered operands driven to the divider
//   Div_Quotient          combinational quotient returned by the divider
//   Rsp_Valid/Rsp_Ready   response handshake
//   Rsp_Quotient          signed quotient (truncated toward zero)
//   Rsp_Grant             0 = response belongs to A, 1 = B
//   Rsp_DivZero           divisor was zero (quotient forced to all ones)

module divider_arbiter #(
    parameter int N      = 32,
    parameter int SETTLE = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,

    input  logic         ReqA_Valid,
    output logic         ReqA_Ready,
    input  logic [N-1:0] ReqA_Dividend,
    input  logic [N-1:0] ReqA_Divisor,

    input  logic         ReqB_Valid,
    output logic         ReqB_Ready,
    input  logic [N-1:0] ReqB_Dividend,
    input  logic [N-1:0] ReqB_Divisor,

    output logic [N-1:0] Div_Dividend,
    output logic [N-1:0] Div_Divisor,
    input  logic [N-1:0] Div_Quotient,

    output logic         Rsp_Valid,
    input  logic         Rsp_Ready,
    output logic [N-1:0] Rsp_Quotient,
    output logic         Rsp_Grant,
    output logic         Rsp_DivZero
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          ptr;
    logic          ptr_nx;
    logic [N-1:0]  dd_q;
    logic [N-1:0]  dd_nx;
    logic [N-1:0]  dv_q;
    logic [N-1:0]  dv_nx;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  quo_nx;
    logic          grant_q;
    logic          grant_nx;
    logic          dz_q;
    logic          dz_nx;

    logic          win_a;
    logic          win_b;

    // ptr = 0 favours A, ptr = 1 favours B; only matters when both are valid.
    always_comb begin
        win_a = ReqA_Valid & (~ReqB_Valid | ~ptr);
        win_b = ReqB_Valid & (~ReqA_Valid |  ptr);
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ptr_nx     = ptr;
        dd_nx      = dd_q;
        dv_nx      = dv_q;
        quo_nx     = quo_q;
        grant_nx   = grant_q;
        dz_nx      = dz_q;
        ReqA_Ready = 1'b0;
        ReqB_Ready = 1'b0;

        unique case (state)
            IDLE: begin
                // Reset_n gates the combinational ready so nothing is
                // acknowledged while the block is held in reset.
                ReqA_Ready = Reset_n & win_a;
                ReqB_Ready = Reset_n & win_b;
                if (win_a | win_b) begin
                    if (ReqA_Valid & ReqB_Valid) begin
                        ptr_nx = ~ptr;
                    end
                    grant_nx = win_b;
                    dd_nx    = win_b ? ReqB_Dividend : ReqA_Dividend;
                    dv_nx    = win_b ? ReqB_Divisor  : ReqA_Divisor;
                    cnt_nx   = CW'(SETTLE - 1);
                    if (dv_nx == '0) begin
                        quo_nx   = '1;
                        dz_nx    = 1'b1;
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end

            WAIT: begin
                // Operands have been stable for SETTLE cycles when cnt hits 0.
                if (cnt == '0) begin
                    quo_nx   = Div_Quotient;
                    dz_nx    = 1'b0;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            RESP: begin
                if (Rsp_Ready) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= 1'b0;
            dd_q    <= '0;
            dv_q    <= '0;
            quo_q   <= '0;
            grant_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ptr     <= ptr_nx;
            dd_q    <= dd_nx;
            dv_q    <= dv_nx;
            quo_q   <= quo_nx;
            grant_q <= grant_nx;
            dz_q    <= dz_nx;
        end
    end

    assign Div_Dividend = dd_q;
    assign Div_Divisor  = dv_q;
    assign Rsp_Valid    = (state == RESP);
    assign Rsp_Quotient = quo_q;
    assign Rsp_Grant    = grant_q;
    assign Rsp_DivZero  = dz_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed bench for divider_arbiter with an
// in-bench divider and a transaction-level reference model.

module tb_divider_arbiter;

    localparam int N      = 32;
    localparam int SETTLE = 4;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         ReqA_Valid;
    logic         ReqA_Ready;
    logic [N-1:0] ReqA_Dividend;
    logic [N-1:0] ReqA_Divisor;
    logic         ReqB_Valid;
    logic         ReqB_Ready;
    logic [N-1:0] ReqB_Dividend;
    logic [N-1:0] ReqB_Divisor;
    logic [N-1:0] Div_Dividend;
    logic [N-1:0] Div_Divisor;
    logic [N-1:0] Div_Quotient;
    logic         Rsp_Valid;
    logic         Rsp_Ready;
    logic [N-1:0] Rsp_Quotient;
    logic         Rsp_Grant;
    logic         Rsp_DivZero;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Signed division truncated toward zero; most-negative / -1 wraps.
    function automatic logic [N-1:0] ref_div(input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        logic [N-1:0] minv;
        minv = {1'b1, {(N-1){1'b0}}};
        if (b == '0) return '0;
        if (a == minv && b == '1) return minv;
        return N'($signed(a) / $signed(b));
    endfunction

    assign Div_Quotient = ref_div(Div_Dividend, Div_Divisor);

    divider_arbiter #(.N(N), .SETTLE(SETTLE)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ReqA_Valid    (ReqA_Valid),
        .ReqA_Ready    (ReqA_Ready),
        .ReqA_Dividend (ReqA_Dividend),
        .ReqA_Divisor  (ReqA_Divisor),
        .ReqB_Valid    (ReqB_Valid),
        .ReqB_Ready    (ReqB_Ready),
        .ReqB_Dividend (ReqB_Dividend),
        .ReqB_Divisor  (ReqB_Divisor),
        .Div_Dividend  (Div_Dividend),
        .Div_Divisor   (Div_Divisor),
        .Div_Quotient  (Div_Quotient),
        .Rsp_Valid     (Rsp_Valid),
        .Rsp_Ready     (Rsp_Ready),
        .Rsp_Quotient  (Rsp_Quotient),
        .Rsp_Grant     (Rsp_Grant),
        .Rsp_DivZero   (Rsp_DivZero)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Reference model: one operation in flight, answered at a fixed time
    // after acceptance, round-robin only decided on contention.
    logic         m_busy;
    logic         m_ptr;
    logic [N-1:0] m_dd;
    logic [N-1:0] m_dv;
    logic [N-1:0] m_q;
    logic         m_g;
    logic         m_dz;
    int           m_rsp_at;

    initial begin
        logic ga;
        logic gb;
        logic rv;
        m_busy   = 1'b0;
        m_ptr    = 1'b0;
        m_dd     = '0;
        m_dv     = '0;
        m_q      = '0;
        m_g      = 1'b0;
        m_dz     = 1'b0;
        m_rsp_at = 0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                m_busy = 1'b0;
                m_ptr  = 1'b0;
                m_dd   = '0;
                m_dv   = '0;
                chk("rst_ready_a", ReqA_Ready, 0);
                chk("rst_ready_b", ReqB_Ready, 0);
                chk("rst_rsp_valid", Rsp_Valid, 0);
                chk("rst_rsp_q", Rsp_Quotient, 0);
                chk("rst_rsp_grant", Rsp_Grant, 0);
                chk("rst_rsp_dz", Rsp_DivZero, 0);
                chk("rst_div_dd", Div_Dividend, 0);
                chk("rst_div_dv", Div_Divisor, 0);
            end else begin
                ga = !m_busy && ReqA_Valid && (!ReqB_Valid || !m_ptr);
                gb = !m_busy && ReqB_Valid && (!ReqA_Valid || m_ptr);
                rv = m_busy && (cyc >= m_rsp_at);
                chk("ready_a", ReqA_Ready, ga);
                chk("ready_b", ReqB_Ready, gb);
                chk("rsp_valid", Rsp_Valid, rv);
                chk("div_dd", Div_Dividend, m_dd);
                chk("div_dv", Div_Divisor, m_dv);
                if (rv) begin
                    chk("rsp_q", Rsp_Quotient, m_q);
                    chk("rsp_grant", Rsp_Grant, m_g);
                    chk("rsp_dz", Rsp_DivZero, m_dz);
                end
                if (ga || gb) begin
                    if (ReqA_Valid && ReqB_Valid) m_ptr = !m_ptr;
                    m_g      = gb;
                    m_dd     = gb ? ReqB_Dividend : ReqA_Dividend;
                    m_dv     = gb ? ReqB_Divisor  : ReqA_Divisor;
                    m_dz     = (m_dv == '0);
                    m_q      = m_dz ? '1 : ref_div(m_dd, m_dv);
                    m_rsp_at = cyc + 1 + (m_dz ? 0 : SETTLE);
                    m_busy   = 1'b1;
                end else if (rv && Rsp_Ready) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    task automatic present(input logic s, input logic [N-1:0] dd,
                           input logic [N-1:0] dv);
        if (s) begin
            ReqB_Valid    = 1'b1;
            ReqB_Dividend = dd;
            ReqB_Divisor  = dv;
        end else begin
            ReqA_Valid    = 1'b1;
            ReqA_Dividend = dd;
            ReqA_Divisor  = dv;
        end
    endtask

    task automatic drop(input logic s);
        if (s) ReqB_Valid = 1'b0;
        else   ReqA_Valid = 1'b0;
    endtask

    // Returns just after the accepting edge.
    task automatic wait_accept(output logic side, output int t);
        int n;
        n = 0;
        @(negedge Clk);
        while (!(ReqA_Ready || ReqB_Ready) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("accept_seen", ReqA_Ready || ReqB_Ready, 1);
        side = ReqB_Ready;
        t    = cyc;
        @(posedge Clk);
        #1;
    endtask

    // Waits for the response, leaves it stalled for hold cycles, takes it.
    task automatic wait_rsp(input int t0, input int hold,
                            output logic [N-1:0] q, output logic g,
                            output logic dz, output int lat);
        int n;
        n = 0;
        @(negedge Clk);
        while (!Rsp_Valid && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("rsp_seen", Rsp_Valid, 1);
        lat = cyc - t0;
        q   = Rsp_Quotient;
        g   = Rsp_Grant;
        dz  = Rsp_DivZero;
        repeat (hold) @(posedge Clk);
        #1;
        Rsp_Ready = 1'b1;
        @(posedge Clk);
        #1;
        Rsp_Ready = 1'b0;
    endtask

    task automatic one_op(input logic s, input logic [N-1:0] dd,
                          input logic [N-1:0] dv, input int hold,
                          output logic [N-1:0] q, output logic dz,
                          output int lat);
        logic side;
        logic g;
        int   t;
        present(s, dd, dv);
        wait_accept(side, t);
        drop(s);
        chk("op_side", side, s);
        wait_rsp(t, hold, q, g, dz, lat);
        chk("op_grant", g, s);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    logic [N-1:0] dd_t [8];
    logic [N-1:0] dv_t [8];
    logic [N-1:0] q_t  [8];

    initial begin
        logic [N-1:0] q;
        logic         dz;
        logic         g;
        logic         side;
        int           lat;
        int           t;

        dd_t = '{32'h8000_0000, 32'd7, -32'sd7, -32'sd7,
                 32'd0, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff};
        dv_t = '{32'hffff_ffff, -32'sd2, 32'd2, -32'sd2,
                 32'd5, 32'd1, 32'd2, 32'h8000_0000};
        q_t  = '{32'h8000_0000, 32'hffff_fffd, 32'hffff_fffd, 32'd3,
                 32'd0, 32'h7fff_ffff, 32'hc000_0000, 32'd0};

        Reset_n       = 1'b0;
        ReqA_Valid    = 1'b1;
        ReqA_Dividend = 32'd1;
        ReqA_Divisor  = 32'd1;
        ReqB_Valid    = 1'b0;
        ReqB_Dividend = '0;
        ReqB_Divisor  = '0;
        Rsp_Ready     = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n    = 1'b1;
        ReqA_Valid = 1'b0;
        @(posedge Clk);
        #1;

        // A only: 100 / 7
        one_op(1'b0, 32'd100, 32'd7, 1, q, dz, lat);
        chk("t1_lat", lat, SETTLE + 1);
        chk("t1_q", q, 32'd14);
        chk("t1_dz", dz, 0);

        // B only: -100 / 7
        one_op(1'b1, -32'sd100, 32'd7, 1, q, dz, lat);
        chk("t2_q", q, 32'hffff_fff2);
        chk("t2_dz", dz, 0);

        // Contention from reset: grants A, B, A, then leftover B.
        do_reset();
        present(1'b0, 32'd60, 32'd5);
        present(1'b1, 32'd81, 32'd9);
        wait_accept(side, t);
        chk("t3_g1", side, 0);
        present(1'b0, 32'd99, -32'sd3);
        wait_rsp(t, 3, q, g, dz, lat);
        chk("t3_q1", q, 32'd12);
        wait_accept(side, t);
        chk("t3_g2", side, 1);
        present(1'b1, 32'd40, 32'd8);
        wait_rsp(t, 3, q, g, dz, lat);
        chk("t3_q2", q, 32'd9);
        chk("t3_rg2", g, 1);
        wait_accept(side, t);
        chk("t3_g3", side, 0);
        drop(1'b0);
        wait_rsp(t, 3, q, g, dz, lat);
        chk("t3_q3", q, 32'hffff_ffdf);
        wait_accept(side, t);
        chk("t3_g4", side, 1);
        drop(1'b1);
        wait_rsp(t, 3, q, g, dz, lat);
        chk("t3_q4", q, 32'd5);

        // Divide by zero answers on the next cycle.
        one_op(1'b0, 32'd5, 32'd0, 2, q, dz, lat);
        chk("t4_lat", lat, 1);
        chk("t4_q", q, 32'hffff_ffff);
        chk("t4_dz", dz, 1);

        // Asynchronous reset in the middle of WAIT drops the operation.
        present(1'b0, 32'd50, 32'd5);
        wait_accept(side, t);
        drop(1'b0);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (8) @(posedge Clk);
        #1;
        one_op(1'b0, 32'd9, 32'd3, 1, q, dz, lat);
        chk("t5_q", q, 32'd3);

        // Signed corner table, then random operands.
        for (int i = 0; i < 8; i++) begin
            one_op(i[0], dd_t[i], dv_t[i], 1 + (i % 3), q, dz, lat);
            chk("t6_q", q, q_t[i]);
        end
        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            one_op(1'($urandom_range(0, 1)), a, b,
                   $urandom_range(1, 3), q, dz, lat);
        end

        repeat (3) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
